// File: rtl/load_scoreboard_hazard.sv
// load_scoreboard_hazard
//   Load-use hazard unit for the variable-latency data-memory path. An
//   in-order FIFO scoreboard records the rd of every load issued to EX
//   until its memory response arrives. stall_o holds IF/ID and bubbles
//   ID/EX while the instruction in ID reads (RAW) or overwrites (WAW) a
//   pending load destination, or is itself a load that cannot be accepted.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   issue_valid_i, issue_is_load_i  a load leaves ID/EX into EX this cycle
//   issue_rd_i                      destination of that load
//   id_rs1_i/id_rs2_i, id_uses_*_i  sources of the ID instruction and their use
//   id_rd_i, id_writes_rd_i         destination of the ID instruction
//   id_is_load_i                    ID instruction is a load
//   mem_rsp_valid_i                 oldest outstanding load returns this cycle
//   stall_o                         hazard, zero-cycle combinational
//   pending_cnt_o, full_o, empty_o  scoreboard occupancy (registered decodes)
//   err_overflow_o, err_underflow_o sticky protocol errors

module load_scoreboard_hazard #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned REG_IDX_W  = 5,
  parameter bit          BYPASS_RSP = 1'b1,
  parameter bit          CHECK_WAW  = 1'b1,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid_i,
  input  logic                 issue_is_load_i,
  input  logic [REG_IDX_W-1:0] issue_rd_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_writes_rd_i,
  input  logic                 id_is_load_i,
  input  logic                 mem_rsp_valid_i,
  output logic                 stall_o,
  output logic [CNT_W-1:0]     pending_cnt_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_overflow_o,
  output logic                 err_underflow_o
);

  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][REG_IDX_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0]                head_q, head_d;
  logic [PTR_W-1:0]                tail_q, tail_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            err_ov_q, err_ov_d;
  logic                            err_un_q, err_un_d;

  logic alloc_req, do_alloc, do_retire;
  logic full, empty;

  // Wrap modulo DEPTH explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign alloc_req = issue_valid_i && issue_is_load_i;
  assign do_retire = mem_rsp_valid_i && !empty;
  // A retire in the same cycle frees the head slot before the tail writes it.
  assign do_alloc  = alloc_req && (!full || do_retire);

  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    err_ov_d = err_ov_q;
    err_un_d = err_un_q;

    if (do_retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    // Applied after retire: when full, tail == head and the slot is reused.
    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = issue_rd_i;
      tail_d          = ptr_inc(tail_q);
    end

    case ({do_alloc, do_retire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (alloc_req && full && !mem_rsp_valid_i) err_ov_d = 1'b1;
    if (mem_rsp_valid_i && empty)              err_un_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rd_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      err_ov_q <= err_ov_d;
      err_un_q <= err_un_d;
    end
  end

  // Entries still able to cause a hazard. With the WB forward present the
  // head entry returning this cycle no longer blocks.
  logic [DEPTH-1:0] live;
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = valid_q[i] &&
                !(BYPASS_RSP && mem_rsp_valid_i && (PTR_W'(i) == head_q));
    end
  end

  logic match_rs1, match_rs2, match_rd;
  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
    match_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (rd_q[i] == id_rs1_i)) match_rs1 = 1'b1;
      if (live[i] && (rd_q[i] == id_rs2_i)) match_rs2 = 1'b1;
      if (live[i] && (rd_q[i] == id_rd_i))  match_rd  = 1'b1;
    end
    // x0 is never a real dependency, even though x0 loads occupy a slot.
    if (id_rs1_i == '0) match_rs1 = 1'b0;
    if (id_rs2_i == '0) match_rs2 = 1'b0;
    if (id_rd_i  == '0) match_rd  = 1'b0;
  end

  assign stall_o = (id_uses_rs1_i && match_rs1)
                 | (id_uses_rs2_i && match_rs2)
                 | (CHECK_WAW && id_writes_rd_i && match_rd)
                 | (id_is_load_i && full && !mem_rsp_valid_i);

  assign pending_cnt_o   = cnt_q;
  assign full_o          = full;
  assign empty_o         = empty;
  assign err_overflow_o  = err_ov_q;
  assign err_underflow_o = err_un_q;

endmodule
